// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Brief    : Shared state encoding and address map for the 3x3 matrix-multiply
//            job sequencer and its Wishbone slave.
// Revision : 1.0
// ============================================================================
package mm_pkg;

    localparam int A_BASE = 0;
    localparam int C_BASE = 18;
    localparam int N_IN   = 18;
    localparam int N_OUT  = 9;
    localparam int IDX_W  = 5;

    localparam logic [3:0] WB_SEL_BYTE0 = 4'b0001;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_GAP    = 3'd2,
        ST_READ   = 3'd3,
        ST_OUT    = 3'd4,
        ST_ERROR  = 3'd5
    } mm_state_e;

endpackage : mm_pkg
`default_nettype wire

// File: rtl/wb_txn_timer.sv
`default_nettype none
// ============================================================================
// Module   : wb_txn_timer
// Brief    : Per-transaction watchdog; flags a bus cycle that waits TIMEOUT
//            cycles without a response.
// Revision : 1.0
// ============================================================================
module wb_txn_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = r_count + CNT_W'(1);

    // Fires in the cycle whose increment would reach TIMEOUT, so the owner
    // leaves the wait state after exactly TIMEOUT cycles in it.
    assign expired = en && (w_count_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_count_inc;
        end
    end

endmodule : wb_txn_timer
`default_nettype wire

// File: rtl/mm_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mm_job_sequencer
// Brief    : Wishbone master that streams 18 operand bytes into the 3x3
//            matrix-multiply slave and streams the 9 result bytes back out.
// Revision : 1.0
// ============================================================================
module mm_job_sequencer
    import mm_pkg::*;
#(
    parameter int A_BASE  = mm_pkg::A_BASE,
    parameter int C_BASE  = mm_pkg::C_BASE,
    parameter int N_IN    = mm_pkg::N_IN,
    parameter int N_OUT   = mm_pkg::N_OUT,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_mosi,
    input  logic [31:0] wb_dat_miso,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic        clr_err,
    output logic        busy,
    output logic        error
);

    localparam logic [IDX_W-1:0] c_last_in  = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] c_last_out = IDX_W'(N_OUT - 1);
    localparam logic [31:0]      c_a_base   = 32'(A_BASE);
    localparam logic [31:0]      c_c_base   = 32'(C_BASE);

    mm_state_e        r_state;
    mm_state_e        r_after_gap;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_byte;
    logic [7:0]       r_out_data;

    mm_state_e        w_state_nxt;
    mm_state_e        w_after_gap_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [7:0]       w_byte_nxt;
    logic [7:0]       w_out_data_nxt;

    logic             w_in_bus;
    logic             w_in_fire;
    logic             w_expired;
    logic [31:0]      w_idx_ext;
    logic             w_unused_miso;

    assign w_unused_miso = ^wb_dat_miso[31:8];

    assign w_in_bus  = (r_state == ST_WR_REQ) || (r_state == ST_READ);
    assign w_idx_ext = {{(32 - IDX_W){1'b0}}, r_idx};

    // Gated by rst_n so the stream stays stalled while reset is held.
    assign in_ready  = rst_n && (r_state == ST_LOAD);
    assign w_in_fire = in_valid && in_ready;

    wb_txn_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_txn_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!w_in_bus),
        .en      (w_in_bus),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_after_gap <= ST_LOAD;
            r_idx       <= '0;
            r_byte      <= '0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_after_gap <= w_after_gap_nxt;
            r_idx       <= w_idx_nxt;
            r_byte      <= w_byte_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_after_gap_nxt = r_after_gap;
        w_idx_nxt       = r_idx;
        w_byte_nxt      = r_byte;
        w_out_data_nxt  = r_out_data;

        case (r_state)
            ST_LOAD: begin
                if (w_in_fire) begin
                    w_byte_nxt  = in_data;
                    w_state_nxt = ST_WR_REQ;
                end
            end

            ST_WR_REQ: begin
                // err takes priority over a simultaneous ack
                if (wb_err || w_expired) begin
                    w_state_nxt = ST_ERROR;
                end else if (wb_ack) begin
                    w_state_nxt = ST_GAP;
                    if (r_idx == c_last_in) begin
                        w_idx_nxt       = '0;
                        w_after_gap_nxt = ST_READ;
                    end else begin
                        w_idx_nxt       = r_idx + IDX_W'(1);
                        w_after_gap_nxt = ST_LOAD;
                    end
                end
            end

            // One idle cycle swallows a repeated registered ack from the slave.
            ST_GAP: begin
                w_state_nxt = r_after_gap;
            end

            ST_READ: begin
                if (wb_err || w_expired) begin
                    w_state_nxt = ST_ERROR;
                end else if (wb_ack) begin
                    w_out_data_nxt = wb_dat_miso[7:0];
                    w_state_nxt    = ST_OUT;
                end
            end

            ST_OUT: begin
                if (out_ready) begin
                    w_state_nxt = ST_GAP;
                    if (r_idx == c_last_out) begin
                        w_idx_nxt       = '0;
                        w_after_gap_nxt = ST_LOAD;
                    end else begin
                        w_idx_nxt       = r_idx + IDX_W'(1);
                        w_after_gap_nxt = ST_READ;
                    end
                end
            end

            ST_ERROR: begin
                if (clr_err) begin
                    w_state_nxt     = ST_LOAD;
                    w_after_gap_nxt = ST_LOAD;
                    w_idx_nxt       = '0;
                end
            end

            default: begin
                w_state_nxt     = ST_LOAD;
                w_after_gap_nxt = ST_LOAD;
                w_idx_nxt       = '0;
            end
        endcase
    end

    assign wb_cyc      = w_in_bus;
    assign wb_stb      = w_in_bus;
    assign wb_we       = (r_state == ST_WR_REQ);
    assign wb_sel      = w_in_bus ? WB_SEL_BYTE0 : 4'b0000;
    assign wb_dat_mosi = (r_state == ST_WR_REQ) ? {24'd0, r_byte} : 32'd0;

    always_comb begin
        wb_adr = 32'd0;
        if (r_state == ST_WR_REQ) begin
            wb_adr = c_a_base + w_idx_ext;
        end else if (r_state == ST_READ) begin
            wb_adr = c_c_base + w_idx_ext;
        end
    end

    assign out_valid = (r_state == ST_OUT);
    assign out_last  = (r_state == ST_OUT) && (r_idx == c_last_out);
    assign out_data  = r_out_data;
    assign busy      = !((r_state == ST_LOAD) && (r_idx == '0));
    assign error     = (r_state == ST_ERROR);

endmodule : mm_job_sequencer
`default_nettype wire

// File: tb/tb_mm_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_job_sequencer
// Brief    : Scoreboard bench for mm_job_sequencer with a behavioural matrix
//            slave on the Wishbone side.
// Revision : 1.0
// ============================================================================
module tb_mm_job_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_mosi;
    logic [31:0] wb_dat_miso;
    logic        wb_ack;
    logic        wb_err;
    logic        clr_err;
    logic        busy;
    logic        error;

    always #5 clk = ~clk;

    mm_job_sequencer #(
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .wb_cyc      (wb_cyc),
        .wb_stb      (wb_stb),
        .wb_we       (wb_we),
        .wb_sel      (wb_sel),
        .wb_adr      (wb_adr),
        .wb_dat_mosi (wb_dat_mosi),
        .wb_dat_miso (wb_dat_miso),
        .wb_ack      (wb_ack),
        .wb_err      (wb_err),
        .clr_err     (clr_err),
        .busy        (busy),
        .error       (error)
    );

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];
    int          out_total = 0;
    logic [7:0]  ops [18];
    logic [7:0]  res [9];

    int          ack_hold = 1;
    bit          err_on_11 = 1'b0;
    bit          never_ack_read = 1'b0;
    int          wr_acks = 0;
    int          rd_acks = 0;
    logic [31:0] wr_log[$];
    int          compute_cnt = 0;
    int          ack_left = 0;
    logic [7:0]  mem [27];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    function automatic void bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endfunction

    function automatic logic [7:0] c_elem(input int i);
        logic [7:0] acc;
        acc = 8'd0;
        for (int k = 0; k < 3; k++)
            acc = acc + mem[(i / 3) * 3 + k] * mem[9 + k * 3 + (i % 3)];
        return acc;
    endfunction

    // Behavioural matrix slave: acks one cycle after strobe, holds ack for
    // ack_hold cycles, and withholds read acks while "computing".
    initial begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
        wb_dat_miso = 32'd0;
        for (int i = 0; i < 27; i++) mem[i] = 8'd0;
        forever begin
            @(negedge clk);
            if (compute_cnt > 0) compute_cnt--;
            if (wb_err) wb_err = 1'b0;
            if (ack_left > 0) begin
                ack_left--;
                if (ack_left == 0) wb_ack = 1'b0;
            end else if (wb_cyc && wb_stb && rst_n) begin
                chk("wb_sel", {28'd0, wb_sel}, 32'd1);
                if (wb_we) begin
                    if (err_on_11 && wb_adr == 32'd11) begin
                        wb_err = 1'b1;
                    end else if (wb_adr < 32'd18) begin
                        chk("wr_data_upper", {8'd0, wb_dat_mosi[31:8]}, 32'd0);
                        mem[wb_adr[4:0]] = wb_dat_mosi[7:0];
                        wr_log.push_back(wb_adr);
                        wr_acks++;
                        wb_ack = 1'b1;
                        ack_left = ack_hold;
                        if (wb_adr == 32'd17) compute_cnt = 4;
                    end
                end else if (!never_ack_read && compute_cnt == 0 &&
                             wb_adr >= 32'd18 && wb_adr < 32'd27) begin
                    wb_dat_miso = {24'hA5C35A, c_elem(int'(wb_adr) - 18)};
                    rd_acks++;
                    wb_ack = 1'b1;
                    ack_left = ack_hold;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every handshake, checks stalls.
    initial begin
        logic [7:0] prev_data;
        bit         prev_stall;
        logic [8:0] e;
        prev_data  = 8'd0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall && out_valid)
                chk("out_data_stable", {24'd0, out_data}, {24'd0, prev_data});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    bound_fail("unexpected_out_byte");
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
                    chk("out_last", {31'd0, out_last}, {31'd0, e[8]});
                end
                out_total++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) bound_fail("in_ready_wait");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_ops(input int cnt, input bit rnd);
        for (int i = 0; i < cnt; i++)
            send_byte(ops[i], rnd ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic push_expected();
        for (int i = 0; i < 9; i++) exp_q.push_back({(i == 8), res[i]});
    endtask

    task automatic wait_out(input int target, input string name);
        int n;
        n = 0;
        while (out_total < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (out_total < target) bound_fail(name);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("clr_error", {31'd0, error}, 32'd0);
        chk("clr_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"},  {24'd0, out_data},  32'd0);
        chk({tag, "_out_last"},  {31'd0, out_last},  32'd0);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
        chk({tag, "_error"},     {31'd0, error},     32'd0);
        chk({tag, "_wb_cyc"},    {31'd0, wb_cyc},    32'd0);
        chk({tag, "_wb_stb"},    {31'd0, wb_stb},    32'd0);
        chk({tag, "_wb_we"},     {31'd0, wb_we},     32'd0);
        chk({tag, "_wb_sel"},    {28'd0, wb_sel},    32'd0);
        chk({tag, "_wb_adr"},    wb_adr,             32'd0);
        chk({tag, "_wb_mosi"},   wb_dat_mosi,        32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        #1 chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Identity A, B = 1..9 -> C = B
        for (int i = 0; i < 9; i++) begin
            ops[i]     = (i % 4 == 0) ? 8'd1 : 8'd0;
            ops[9 + i] = 8'(i + 1);
            res[i]     = 8'(i + 1);
        end
        wr_acks = 0; rd_acks = 0;
        push_expected();
        send_ops(18, 1'b0);
        wait_out(9, "identity_outputs");
        chk("identity_busy_in_gap", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("identity_busy_after_gap", {31'd0, busy}, 32'd0);
        chk("identity_in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("identity_wr_acks", wr_acks, 32'd18);
        chk("identity_rd_acks", rd_acks, 32'd9);

        // Backpressure: A = diag(1,2,3), B = 1..9
        for (int i = 0; i < 9; i++) ops[i] = (i % 4 == 0) ? 8'(i / 4 + 1) : 8'd0;
        res = '{8'd1, 8'd2, 8'd3, 8'd8, 8'd10, 8'd12, 8'd21, 8'd24, 8'd27};
        base = out_total;
        push_expected();
        send_ops(18, 1'b1);
        wait_out(base + 3, "bp_first3");
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) bound_fail("bp_byte4_wait");
        chk("bp_byte4_data", {24'd0, out_data}, 32'd8);
        repeat (4) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_data", {24'd0, out_data}, 32'd8);
        end
        out_ready = 1'b1;
        wait_out(base + 9, "bp_outputs");
        @(negedge clk);

        // Double ack: A = all 1s, B = 1..9
        for (int i = 0; i < 9; i++) ops[i] = 8'd1;
        res = '{8'd12, 8'd15, 8'd18, 8'd12, 8'd15, 8'd18, 8'd12, 8'd15, 8'd18};
        ack_hold = 2;
        wr_log.delete();
        base = out_total;
        push_expected();
        send_ops(18, 1'b0);
        wait_out(base + 9, "dack_outputs");
        @(negedge clk);
        ack_hold = 1;
        chk("dack_write_count", wr_log.size(), 32'd18);
        for (int i = 0; i < 18 && i < wr_log.size(); i++)
            chk("dack_write_addr", wr_log[i], 32'(i));

        // Bus error on the write to address 11
        for (int i = 0; i < 9; i++) ops[i] = (i % 4 == 0) ? 8'd2 : 8'd0;
        err_on_11 = 1'b1;
        wr_acks = 0;
        send_ops(12, 1'b0);
        n = 0;
        while (!error && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("err_error", {31'd0, error}, 32'd1);
        chk("err_wb_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("err_in_ready", {31'd0, in_ready}, 32'd0);
        chk("err_out_valid", {31'd0, out_valid}, 32'd0);
        chk("err_wr_acks", wr_acks, 32'd11);
        err_on_11 = 1'b0;
        pulse_clr();

        // New job after error: A = 2*I, B = 1..9
        res = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14, 8'd16, 8'd18};
        base = out_total;
        push_expected();
        send_ops(18, 1'b0);
        wait_out(base + 9, "post_err_outputs");
        @(negedge clk);

        // Timeout on the read of address 18
        never_ack_read = 1'b1;
        send_ops(18, 1'b0);
        n = 0;
        while (!(wb_cyc && !wb_we) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("to_read_adr", wb_adr, 32'd18);
        n = 0;
        while (!error && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", n, 32'd16);
        chk("to_error", {31'd0, error}, 32'd1);
        chk("to_wb_cyc", {31'd0, wb_cyc}, 32'd0);
        never_ack_read = 1'b0;
        pulse_clr();

        // Reset after 7 operand bytes, then A = B = all 2s
        for (int i = 0; i < 18; i++) ops[i] = 8'd9;
        send_ops(7, 1'b0);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 18; i++) ops[i] = 8'd2;
        for (int i = 0; i < 9; i++) res[i] = 8'd12;
        base = out_total;
        push_expected();
        send_ops(18, 1'b0);
        wait_out(base + 9, "twos_outputs");
        @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mm_job_sequencer
`default_nettype wire
